// File: rtl/pattern_tx_pkg.sv
// Shared types and default framing constants for the serial frame transmitter.
// The default sync pattern matches what the team's 1011 sequence detectors recognise.
package pattern_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int              DEF_PAT_W  = 4;
    localparam logic [3:0]      DEF_PAT    = 4'b1011;
    localparam int              DEF_DATA_W = 8;

    // Bit counter width: enough to hold max(a,b)-1, never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pattern_tx_if.sv
// Start handshake, payload and serial output of the frame transmitter.
// slave is the transmitter side, master is whoever requests frames and watches the line.
interface pattern_tx_if
    import pattern_tx_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              start;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              o;
    logic              o_valid;
    logic              done;

    modport master (
        output start,
        output data,
        input  ready,
        input  o,
        input  o_valid,
        input  done
    );

    modport slave (
        input  start,
        input  data,
        output ready,
        output o,
        output o_valid,
        output done
    );

endinterface

// File: rtl/pattern_tx_shreg.sv
// Loadable left-shift register holding {sync pattern, payload}; msb is the bit on the line.
// Zeros are shifted in from the right; they are never transmitted.
module pattern_tx_shreg #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sr_reg;

    // Load has priority so an accept in the done cycle always captures the new frame.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sr_reg <= '0;
        end else if (load) begin
            sr_reg <= din;
        end else if (shift) begin
            sr_reg <= {sr_reg[W-2:0], 1'b0};
        end
    end

    assign msb = sr_reg[W-1];

endmodule

// File: rtl/pattern_tx.sv
// Serial frame transmitter: on an accepted start, sends PAT then the latched data word,
// both MSB first, one bit per clock, followed by a one-cycle done pulse.
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int               PAT_W    = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PAT      = DEF_PAT,
    parameter int               DATA_W   = DEF_DATA_W,
    parameter logic             IDLE_BIT = 1'b0
) (
    input  logic           clk,
    input  logic           rst_b,
    pattern_tx_if.slave    bus
);

    localparam int FRAME_W = PAT_W + DATA_W;
    localparam int CNT_W   = cnt_width(PAT_W, DATA_W);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             ready_reg;
    logic             o_valid_reg;
    logic             done_reg;

    logic             sh_load;
    logic             sh_shift;
    logic             sh_msb;

    // The payload is captured only on the accepting edge; later data changes are invisible.
    assign sh_load  = (state_reg == IDLE) && bus.start;
    assign sh_shift = (state_reg != IDLE);

    pattern_tx_shreg #(
        .W (FRAME_W)
    ) u_shreg (
        .clk   (clk),
        .rst_b (rst_b),
        .load  (sh_load),
        .shift (sh_shift),
        .din   ({PAT, bus.data}),
        .msb   (sh_msb)
    );

    // Frame sequencer: counts down the sync bits, then the data bits, then pulses done.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            ready_reg   <= 1'b1;
            o_valid_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg   <= SYNC;
                        cnt_reg     <= SYNC_LAST;
                        ready_reg   <= 1'b0;
                        o_valid_reg <= 1'b1;
                    end
                end
                SYNC: begin
                    if (cnt_reg == '0) begin
                        state_reg <= DATA;
                        cnt_reg   <= DATA_LAST;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_reg == '0) begin
                        state_reg   <= IDLE;
                        ready_reg   <= 1'b1;
                        o_valid_reg <= 1'b0;
                        done_reg    <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    cnt_reg     <= '0;
                    ready_reg   <= 1'b1;
                    o_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Line carries the shift-register MSB while framing, otherwise the idle level.
    assign bus.o       = o_valid_reg ? sh_msb : IDLE_BIT;
    assign bus.o_valid = o_valid_reg;
    assign bus.ready   = ready_reg;
    assign bus.done    = done_reg;

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: table-driven frames, hand-written corner sequences,
// and randomized traffic checked cycle by cycle against a frame-timing reference model.
module tb_pattern_tx;
    import pattern_tx_pkg::*;

    localparam int             PW  = DEF_PAT_W;
    localparam int             DW  = DEF_DATA_W;
    localparam int             FW  = PW + DW;
    localparam logic [PW-1:0]  PAT = DEF_PAT;
    localparam logic           IDLE_BIT = 1'b0;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;

    pattern_tx_if #(.DATA_W(DW)) bus ();

    pattern_tx #(
        .PAT_W    (PW),
        .PAT      (PAT),
        .DATA_W   (DW),
        .IDLE_BIT (IDLE_BIT)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // A frame accepted at the edge ending cycle c occupies cycles c+1 .. c+FW,
    // and cycle c+FW+1 is the done cycle.
    int            cyc         = 0;
    int            frame_start = -1000;
    logic [FW-1:0] frame_bits  = '0;

    function automatic bit model_busy(input int c);
        return (c >= frame_start) && (c < frame_start + FW);
    endfunction

    // Expected {o, o_valid, ready, done} in cycle c.
    function automatic logic [3:0] model_out(input int c);
        int off;
        off = c - frame_start;
        if (off >= 0 && off < FW)
            return {frame_bits[FW-1-off], 1'b1, 1'b0, 1'b0};
        return {IDLE_BIT, 1'b0, 1'b1, (off == FW)};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            frame_start <= -1000;
        end else if (bus.start && !model_busy(cyc)) begin
            frame_start <= cyc + 1;
            frame_bits  <= {PAT, bus.data};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [DW-1:0] data;
        logic [FW-1:0] exp_frame;
        int            exp_pulses;
        bit            noise;
    } vec_t;

    vec_t vecs[5];

    // One frame with a one-cycle start; collects the line and a 1011 detector count.
    task automatic run_frame(input vec_t v);
        logic [FW-1:0] got;
        logic [PW-1:0] hist;
        int            hits;
        int            first_hit;
        int            dones;
        int            rdy_mid;
        check("ready_before_frame", bus.ready, 1);
        bus.start = 1'b1;
        bus.data  = v.data;
        got = '0; hist = '0; hits = 0; first_hit = -1; dones = 0; rdy_mid = 0;
        for (int c = 1; c <= FW + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start = 1'b0;
                bus.data  = DW'($urandom);
            end
            if (c <= FW) begin
                got  = {got[FW-2:0], bus.o};
                hist = {hist[PW-2:0], bus.o};
                if (hist == PAT) begin
                    hits++;
                    if (first_hit < 0) first_hit = c;
                end
                rdy_mid += int'(bus.ready);
            end
            dones += int'(bus.done);
            if (c == FW + 1) check("done_in_done_cycle", bus.done, 1);
            if (v.noise && c == 6) begin
                bus.start = 1'b1;
                bus.data  = DW'($urandom);
            end
            if (v.noise && c == 7) bus.start = 1'b0;
        end
        check("frame_bits", got, v.exp_frame);
        check("detector_pulses", hits, v.exp_pulses);
        check("first_detect_cycle", first_hit, PW);
        check("done_count", dones, 1);
        check("ready_low_mid_frame", rdy_mid, 0);
        repeat (2) @(negedge clk);
        check("no_extra_frame", bus.o_valid, 0);
        $display("frame data=%02h noise=%0d line=%03h pulses=%0d", v.data, v.noise, got, hits);
    endtask

    initial begin
        logic [2*FW:0] got_b2b;
        logic [2*FW:0] exp_b2b;
        int            dones;
        int            accepts;

        vecs[0] = '{8'hA5, 12'hBA5, 1, 1'b0};
        vecs[1] = '{8'hB0, 12'hBB0, 2, 1'b0};
        vecs[2] = '{8'hFF, 12'hBFF, 1, 1'b0};
        vecs[3] = '{8'h00, 12'hB00, 1, 1'b1};
        vecs[4] = '{8'h5B, 12'hB5B, 3, 1'b1};

        bus.start = 1'b1;
        bus.data  = 8'hA5;
        rst_b     = 1'b0;

        // Cycle-by-cycle comparison of every output against the model.
        fork
            forever begin
                @(negedge clk);
                check("cycle_outputs", {bus.o, bus.o_valid, bus.ready, bus.done}, model_out(cyc));
            end
        join_none

        // Reset held with start asserted: line stays idle.
        repeat (4) @(negedge clk);
        check("reset_held_outputs", {bus.o, bus.o_valid, bus.ready, bus.done}, 4'b0010);
        rst_b = 1'b1;
        @(negedge clk);
        check("first_bit_after_release", {bus.o, bus.o_valid, bus.ready}, 3'b110);
        bus.start = 1'b0;
        repeat (FW + 1) @(negedge clk);
        $display("reset release frame checked");

        // Table-driven frames.
        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // Back-to-back: start held, all-ones then all-zeros payload.
        bus.start = 1'b1;
        bus.data  = 8'hFF;
        got_b2b   = '0;
        exp_b2b   = {PAT, 8'hFF, IDLE_BIT, PAT, 8'h00};
        dones     = 0;
        for (int c = 1; c <= 2 * FW + 2; c++) begin
            @(negedge clk);
            if (c == 1) bus.data = 8'h00;
            if (c <= 2 * FW + 1) got_b2b = {got_b2b[2*FW-1:0], bus.o};
            if (c == FW + 1) check("b2b_ready_in_done", {bus.ready, bus.o_valid, bus.done}, 3'b101);
            if (c == FW + 2) bus.start = 1'b0;
            dones += int'(bus.done);
        end
        check("b2b_line", got_b2b, exp_b2b);
        check("b2b_done_count", dones, 2);
        $display("back-to-back line=%07h", got_b2b);
        repeat (2) @(negedge clk);

        // Reset during DATA bit 3 drops the frame asynchronously.
        bus.start = 1'b1;
        bus.data  = 8'h3C;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst_b = 1'b0;
        #1 check("async_reset_mid_frame", {bus.o, bus.o_valid, bus.ready, bus.done}, 4'b0010);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        dones = 0;
        for (int c = 0; c < FW + 2; c++) begin
            @(negedge clk);
            dones += int'(bus.done);
        end
        check("no_done_after_drop", dones, 0);
        $display("mid-frame reset dropped frame");
        run_frame(vecs[0]);

        // Randomized traffic with occasional resets; the model checks every cycle.
        accepts = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst_b     = ($urandom_range(0, 199) != 0);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.data  = DW'($urandom);
            if (bus.start && bus.ready && rst_b) accepts++;
        end
        bus.start = 1'b0;
        rst_b     = 1'b1;
        repeat (FW + 3) @(negedge clk);
        $display("random traffic: %0d accepting cycles", accepts);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
